bcd_seq_converter: RTL and testbench
====================================

// Module: bcd_seq_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Extends the 4-bit combinational converter to WIDTH-bit operands.
//  An FSM sequences a per-digit add-3 adjust datapath under a start/done handshake.
//  Sits between switch/counter sources and the 7-segment digit decoders.
// PARAMETERS
//  WIDTH   8  binary operand width, 4..16
//  DIGITS  3  BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1 (elaboration error otherwise)
// PORTS
//  clk    in   1           single system clock, rising edge
//  rst_n  in   1           reset: synchronous, active-low
//  start  in   1           request conversion of bin; sampled only while ready=1
//  bin    in   WIDTH       binary operand; captured on accepted start, may change afterwards
//  ready  out  1           block can accept start (IDLE or DONE)
//  busy   out  1           conversion in progress (CONVERT)
//  done   out  1           one-cycle pulse: bcd valid
//  bcd    out  4*DIGITS    packed BCD result, digit 0 = bcd[3:0] (units)
//  blank  out  DIGITS      leading-zero mask (BCD_BLANK_EN only; absent otherwise)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, ready=1, busy=0, done=0, bcd=0, blank=0.
//  Reset mid-conversion aborts it: no done pulse, bcd cleared, any start in the same cycle is dropped.
//  FSM: IDLE -(start)-> CONVERT; CONVERT -(bit count = WIDTH-1)-> DONE;
//       DONE -(start)-> CONVERT, else -> IDLE.
//  Accept: edge t with ready=1 and start=1. Loads shift reg <- bin, digit regs <- 0, count <- 0.
//  CONVERT, per cycle: each digit >=5 gets +3 (4-bit, no carry out); then {digits,shift} <<= 1.
//  WIDTH CONVERT cycles total. busy=1 on cycles t+1..t+WIDTH.
//  done=1 for exactly cycle t+WIDTH+1 (DONE state). bcd updates on that same edge.
//  bcd holds its last result until the next done. It does not change during CONVERT (shadow regs).
//  start while busy=1 is ignored; no queuing, no error flag.
//  start in DONE is accepted (back-to-back): next done comes WIDTH+1 cycles later.
//  ready = ~busy. busy and done are never high together.
//  bin=0 yields bcd=0. Max input 2^WIDTH-1 never overflows, given the DIGITS check.
// CONFIGURATION
//  `BCD_BLANK_EN defined: blank[i]=1 iff digit i and all higher digits are 0, for i>=1.
//    blank[0] is always 0 (units shown).
//    Registered with bcd, so it updates on the done edge. Reset value 0.
//  Undefined: blank port and logic removed; nothing else changes.
// STRUCTURE
//  Package bcd_pkg: FSM state enum {IDLE, CONVERT, DONE} (2-bit), BCD_DIGIT_W=4,
//    function clog2 for counter width, add-3 threshold constant 4'd5.
//  Sub-module bcd_add3_cell: 4-bit in/out, out = (in>=5) ? in+3 : in.
//    Instantiated DIGITS times in a generate loop.
//  Top holds the FSM, bit counter, shift/digit regs, output regs.
// TESTING
//  1 WIDTH=8: start, bin=8'd255 -> busy cycles 1..8; done at cycle 9; bcd=12'h255; blank=3'b000.
//  2 bin=8'd0 -> bcd=12'h000, blank=3'b110. bin=8'd9 -> bcd=12'h009, blank=3'b110.
//    bin=8'd40 -> bcd=12'h040, blank=3'b100.
//  3 start with bin=8'd99, then start again at cycle 3 with bin=8'd1
//    -> second start ignored; single done at cycle 9, bcd=12'h099.
//  4 Back-to-back: start=1 on the done cycle with bin=8'd128
//    -> busy next cycle; second done 9 cycles later, bcd=12'h128.
//  5 rst_n=0 at cycle 4 of a conversion -> cycle 5: ready=1, bcd=0, no done pulse.
//  6 Exhaustive sweep bin=0..255 vs reference model, bin changed during busy
//    -> every bcd matches the captured bin.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and elaboration helpers for the BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// rtl/bcd_add3_cell.sv - single-digit add-3 adjust applied before each shift
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential shift-and-add-3 binary-to-BCD converter
// Optional leading-zero mask output enabled by defining BCD_BLANK_EN.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             blank
`endif
);

    localparam int CNT_W = clog2(WIDTH);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("bcd_seq_converter: WIDTH must be within 4..16");
        end
        if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
            $error("bcd_seq_converter: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_count;
    logic [WIDTH-1:0]         r_shift;
    logic [BCD_W-1:0]         r_digits;
    logic [BCD_W-1:0]         r_bcd;
    logic [BCD_W-1:0]         w_adj;
    logic [BCD_W+WIDTH-1:0]   w_shifted;
    logic [BCD_W-1:0]         w_digits_next;
    logic [WIDTH-1:0]         w_shift_next;
    logic                     w_accept;
    logic                     w_last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3_cell u_cell (
                .i_digit (r_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The adjusted digits and the operand shift as one register chain.
    assign w_shifted     = {w_adj, r_shift} << 1;
    assign w_digits_next = w_shifted[BCD_W+WIDTH-1 -: BCD_W];
    assign w_shift_next  = w_shifted[WIDTH-1:0];

    assign busy     = (r_state == CONVERT);
    assign done     = (r_state == DONE);
    assign ready    = ~busy;
    assign bcd      = r_bcd;
    assign w_accept = ready & start;
    assign w_last   = busy && (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CONVERT;
            CONVERT: if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? CONVERT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_shift  <= '0;
            r_digits <= '0;
            r_bcd    <= '0;
        end else begin
            if (w_accept) begin
                r_count  <= '0;
                r_shift  <= bin;
                r_digits <= '0;
            end else if (busy) begin
                r_count  <= r_count + CNT_W'(1);
                r_shift  <= w_shift_next;
                r_digits <= w_digits_next;
            end
            // Shadow output: only the final shift result becomes visible.
            if (w_last) begin
                r_bcd <= w_digits_next;
            end
        end
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    always_comb begin
        logic w_zero_above;
        w_blank_next = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above    = w_zero_above & (w_digits_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            w_blank_next[i] = w_zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if (w_last) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank = r_blank;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - scoreboard bench for bcd_seq_converter (WIDTH=8, DIGITS=3)
module tb_bcd_seq_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin   = 8'd0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
`ifdef BCD_BLANK_EN
    logic [2:0]  blank;
`endif

    bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  blank;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    logic [11:0] prev_bcd = 12'd0;

    always @(posedge clk) cyc++;

    function automatic logic [11:0] bcd_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] blank_ref(input int v);
        return {v < 100, v < 10, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (busy) check("bcd_hold_while_busy", {20'd0, bcd}, {20'd0, prev_bcd});
            prev_bcd = bcd;
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual bcd=%0h required=no done at cycle %0d", bcd, cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_bcd", {20'd0, bcd}, {20'd0, e.bcd});
                    check("done_cycle", cyc, e.cyc);
`ifdef BCD_BLANK_EN
                    check("done_blank", {29'd0, blank}, {29'd0, e.blank});
`endif
                end
            end
        end
    end

    task automatic issue(input logic [7:0] v, input logic [11:0] eb, input logic [2:0] ebl);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual ready=0 required=1 at cycle %0d", cyc);
        end
        start = 1'b1;
        bin   = v;
        sb.push_back('{eb, ebl, cyc + 1 + WIDTH});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || done) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual pending=%0d required=0", sb.size());
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  v;
        logic [11:0] eb;
        logic [2:0]  ebl;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'd0,   12'h000, 3'b110},
        '{8'd9,   12'h009, 3'b110},
        '{8'd40,  12'h040, 3'b100},
        '{8'd10,  12'h010, 3'b100},
        '{8'd100, 12'h100, 3'b000},
        '{8'd200, 12'h200, 3'b000}
    };

    initial begin
        int seen;
        int n;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_busy",  {31'd0, busy},  32'd0);
        check("reset_done",  {31'd0, done},  32'd0);
        check("reset_bcd",   {20'd0, bcd},   32'd0);
`ifdef BCD_BLANK_EN
        check("reset_blank", {29'd0, blank}, 32'd0);
`endif
        rst_n    = 1'b1;
        prev_bcd = bcd;
        mon_en   = 1'b1;
        @(negedge clk);

        // Max operand with busy window edges
        issue(8'd255, 12'h255, 3'b000);
        check("t1_busy_cycle1", {31'd0, busy}, 32'd1);
        repeat (7) @(negedge clk);
        check("t1_busy_cycle8", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("t1_done_cycle9", {31'd0, done}, 32'd1);
        wait_idle();

        foreach (vecs[i]) begin
            issue(vecs[i].v, vecs[i].eb, vecs[i].ebl);
            wait_idle();
        end

        // Start while busy must be ignored
        issue(8'd99, 12'h099, 3'b100);
        repeat (2) @(negedge clk);
        check("t3_ready_busy", {31'd0, ready}, 32'd0);
        start = 1'b1;
        bin   = 8'd1;
        @(negedge clk);
        start = 1'b0;
        bin   = 8'hA5;
        wait_idle();

        // Back-to-back start on the done cycle
        issue(8'd50, 12'h050, 3'b100);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_done_seen", {31'd0, done}, 32'd1);
        issue(8'd128, 12'h128, 3'b000);
        check("t4_busy_after_b2b", {31'd0, busy}, 32'd1);
        wait_idle();

        // Reset aborts a conversion; start during reset is dropped
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        bin   = 8'd5;
        @(negedge clk);
        check("t5_ready", {31'd0, ready}, 32'd1);
        check("t5_busy",  {31'd0, busy},  32'd0);
        check("t5_done",  {31'd0, done},  32'd0);
        check("t5_bcd",   {20'd0, bcd},   32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("t5_no_done", seen, 0);

        // Sweep with operand scrambled during each conversion
        for (int v = 0; v < 256; v++) begin
            issue(8'(v), bcd_ref(v), blank_ref(v));
            bin = 8'($urandom);
        end
        wait_idle();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
